// File: rtl/pht_update_scheduler_if.sv
// Port bundle for the gshare PHT update scheduler: fetch lookup, commit resolve
// and single-port PHT access signals.
`timescale 1ns/1ps
interface pht_update_scheduler_if #(
  parameter int unsigned G_WIDTH = 7,
  parameter int unsigned Q_DEPTH = 4
);
  localparam int unsigned IW = G_WIDTH + 1;
  localparam int unsigned CW = $clog2(Q_DEPTH) + 1;

  logic          lookupValid;
  logic [IW-1:0] lookupIndex;
  logic          predValid;
  logic          predTaken;
  logic          resolveValid;
  logic [IW-1:0] resolveIndex;
  logic          resolveTaken;
  logic          resolveReady;
  logic          phtEn;
  logic          phtWe;
  logic [IW-1:0] phtAddr;
  logic [1:0]    phtWdata;
  logic [1:0]    phtRdata;
  logic [CW-1:0] queueCount;
  logic          busy;

  modport master (
    output lookupValid, lookupIndex, resolveValid, resolveIndex, resolveTaken, phtRdata,
    input  predValid, predTaken, resolveReady, phtEn, phtWe, phtAddr, phtWdata,
           queueCount, busy
  );

  modport slave (
    input  lookupValid, lookupIndex, resolveValid, resolveIndex, resolveTaken, phtRdata,
    output predValid, predTaken, resolveReady, phtEn, phtWe, phtAddr, phtWdata,
           queueCount, busy
  );
endinterface

// File: rtl/pht_update_scheduler.sv
// Shares the single-port gshare PHT between fetch lookups and queued 2-bit counter
// read-modify-write updates. Optional PHT_BYPASS_EN forwards a pending update to fetch.
`timescale 1ns/1ps
module pht_update_scheduler #(
  parameter int unsigned G_WIDTH = 7,
  parameter int unsigned Q_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  pht_update_scheduler_if.slave bus
);
  localparam int unsigned IW = G_WIDTH + 1;
  localparam int unsigned PW = $clog2(Q_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [IW-1:0] index;
    logic          taken;
  } res_t;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR_PEND} state_t;

  res_t          q_mem [Q_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [1:0]    ctr_q, ctr_d;
  logic          pred_valid_q;

  res_t          head;
  logic          resolve_ready, push, pop;
  logic [1:0]    ctr_cur, new_ctr;
  logic          pht_en, pht_we;
  logic [IW-1:0] pht_addr;
  logic [1:0]    pht_wdata;
  logic          pred_taken;

  assign head          = q_mem[rd_ptr_q];
  assign resolve_ready = count_q < CW'(Q_DEPTH);
  assign push          = bus.resolveValid && resolve_ready;

  // Counter under update: fresh read data in RD, captured copy while write is pending
  always_comb begin
    ctr_cur = (state_q == S_RD) ? bus.phtRdata : ctr_q;
    new_ctr = ctr_cur;
    if (head.taken && ctr_cur != 2'd3)
      new_ctr = ctr_cur + 2'd1;
    else if (!head.taken && ctr_cur != 2'd0)
      new_ctr = ctr_cur - 2'd1;
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    pop       = 1'b0;
    pht_en    = 1'b0;
    pht_we    = 1'b0;
    pht_addr  = '0;
    pht_wdata = '0;
    if (bus.lookupValid) begin
      pht_en   = 1'b1;
      pht_addr = bus.lookupIndex;
    end
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0 && !bus.lookupValid) begin
          pht_en   = 1'b1;
          pht_addr = head.index;
          state_d  = S_RD;
        end
      end
      S_RD, S_WR_PEND: begin
        if (state_q == S_RD) ctr_d = bus.phtRdata;
        if (!bus.lookupValid) begin
          pht_en    = 1'b1;
          pht_we    = 1'b1;
          pht_addr  = head.index;
          pht_wdata = new_ctr;
          pop       = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_WR_PEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ctr_q        <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      count_q      <= count_d;
      pred_valid_q <= bus.lookupValid;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Queue payload needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q] <= '{index: bus.resolveIndex, taken: bus.resolveTaken};
  end

`ifdef PHT_BYPASS_EN
  logic [IW-1:0] pred_index_q;
  logic          bypass;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pred_index_q <= '0;
    else       pred_index_q <= bus.lookupIndex;
  end

  assign bypass     = (state_q == S_RD || state_q == S_WR_PEND) && (pred_index_q == head.index);
  assign pred_taken = pred_valid_q && (bypass ? new_ctr[1] : bus.phtRdata[1]);
`else
  assign pred_taken = pred_valid_q && bus.phtRdata[1];
`endif

  // Reset forces every output low, including the combinational port controls
  assign bus.phtEn        = pht_en && !reset;
  assign bus.phtWe        = pht_we && !reset;
  assign bus.phtAddr      = reset ? '0 : pht_addr;
  assign bus.phtWdata     = reset ? '0 : pht_wdata;
  assign bus.resolveReady = resolve_ready && !reset;
  assign bus.predValid    = pred_valid_q;
  assign bus.predTaken    = pred_taken && !reset;
  assign bus.queueCount   = count_q;
  assign bus.busy         = (state_q != S_IDLE || count_q != '0) && !reset;
endmodule

// File: doc/pht_update_scheduler.md
Name: pht_update_scheduler

Overview:
- Sequences the single-port pattern history table (PHT) of the gshare predictor.
- Shares the one port between fetch-side prediction lookups, which take an index from the branch index unit, and commit-side branch resolutions.
- Resolutions are queued and applied as read-modify-write updates of 2-bit saturating counters.
- Lookups always win the port; updates use idle cycles.

Parameters:
- G_WIDTH, 7, MSB of PHT index; index is G_WIDTH+1 bits, PHT has 2^(G_WIDTH+1) entries.
- Q_DEPTH, 4, resolution queue depth (power of 2, >=2).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- lookupValid  input  1  fetch requests a prediction this cycle.
- lookupIndex  input  G_WIDTH+1  PHT index for the lookup.
- predValid  output  1  prediction valid; one cycle after lookupValid.
- predTaken  output  1  predicted direction (counter MSB).
- resolveValid  input  1  resolved branch offered.
- resolveIndex  input  G_WIDTH+1  index used when that branch was predicted.
- resolveTaken  input  1  actual outcome.
- resolveReady  output  1  queue can accept (count < Q_DEPTH).
- phtEn  output  1  PHT port access this cycle.
- phtWe  output  1  access is a write.
- phtAddr  output  G_WIDTH+1  PHT address.
- phtWdata  output  2  counter write value.
- phtRdata  input  2  read data; valid the cycle after a read access.
- queueCount  output  $clog2(Q_DEPTH)+1  entries queued.
- busy  output  1  FSM not IDLE or queue non-empty.

Behaviour:
- Reset (async, any time including mid-update): queue emptied, FSM to IDLE, all outputs 0. An in-flight update is discarded; no partial write occurs.
- Queue: FIFO of {index, taken}.
  - Push when resolveValid && resolveReady.
  - Pop only on the update write cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - resolveValid while !resolveReady: not accepted; the upstream holds the request.
  - Pointers wrap modulo Q_DEPTH.
- Lookup path:
  - lookupValid drives phtEn=1, phtWe=0, phtAddr=lookupIndex combinationally.
  - predValid is lookupValid registered.
  - predTaken = phtRdata[1] while predValid, else 0.
  - Lookups are never stalled.
- FSM (update path):
  - IDLE: if queue non-empty and !lookupValid, read the head index (phtEn=1, phtWe=0) and go to RD.
  - RD: capture phtRdata into ctrReg and compute newCtr.
    - If !lookupValid: write newCtr to the head index this cycle (phtEn=1, phtWe=1), pop, go to IDLE.
    - Else: go to WR_PEND.
  - WR_PEND: hold ctrReg/newCtr. When !lookupValid, write, pop, go to IDLE.
- newCtr saturating rules:
  - taken && ctr!=3 gives ctr+1.
  - !taken && ctr!=0 gives ctr-1.
  - Otherwise ctr is unchanged (3 stays 3 on taken; 0 stays 0 on not-taken).
- Ordering: one update in flight at a time. A write precedes the next read, so back-to-back updates to the same index compound correctly.
- Starvation: continuous lookups hold the FSM in IDLE/WR_PEND indefinitely. This is permitted, and the queue applies back-pressure through resolveReady.
- phtWe=1 only in RD/WR_PEND write cycles; phtWdata=0 when not writing.

Optional Feature:
- PHT_BYPASS_EN defined: if a lookup's registered index equals the head index while FSM is in WR_PEND (or in RD, where newCtr is known), predTaken = newCtr[1] instead of phtRdata[1].
  - Fetch sees the pending update.
  - The comparison uses the lookup index registered alongside predValid.
- Undefined: predTaken always = phtRdata[1]; a lookup may return the stale pre-update counter.

Test Plan:
- Reset then idle: all outputs 0, resolveReady=1, queueCount=0, no phtEn for 5 cycles.
- Single update, no lookups: push {idx=8'h2A, taken=1}; phtRdata=2'b01 in RD → write addr 8'h2A data 2'b10 two cycles after push; queueCount back to 0.
- Saturation: ctr=3 with taken=1 → writes 3; ctr=0 with taken=0 → writes 0.
- Lookup preemption: queue holds 1 entry, lookupValid held 3 cycles starting in RD → FSM in WR_PEND, no write until lookupValid drops, then one write, pop. predValid asserts each following cycle.
- Full queue: push 4 entries while lookupValid=1 continuously → resolveReady=0, queueCount=4, a fifth resolveValid is not accepted. Release lookups → 4 writes in FIFO order, resolveReady=1 after the first pop.
- Async reset asserted in WR_PEND with 3 queued → immediately queueCount=0, busy=0, phtEn=0, no write after release.
